// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel frame deserializer
// Collects MSB-first serial bits into a DATA_W word; a gap closes short frames.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [3:0]        deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {IDLE_S, RECV_S} state_t;

  state_t              state_q;
  logic [4:0]          cnt_q;
  logic [DATA_W-1:0]   buf_q;
  logic [DATA_W-1:0]   buf_d;
  logic [4:0]          idx;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          mod_q;
  logic                val_q;

  // Unreceived positions in buf_q are always 0, so OR-ing in the new bit is enough.
  always_comb begin
    idx   = 5'(DATA_W - 1) - cnt_q;
    buf_d = buf_q | ({{(DATA_W-1){1'b0}}, ser_data_i} << idx);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      val_q <= 1'b0;
      case (state_q)
        IDLE_S: begin
          if (ser_data_val_i) begin
            buf_q   <= {ser_data_i, {(DATA_W-1){1'b0}}};
            cnt_q   <= 5'd1;
            state_q <= RECV_S;
          end
        end
        RECV_S: begin
          if (ser_data_val_i) begin
            if (cnt_q == 5'(DATA_W - 1)) begin
              data_q  <= buf_d;
              mod_q   <= 4'd0;
              val_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= IDLE_S;
            end else begin
              buf_q <= buf_d;
              cnt_q <= cnt_q + 5'd1;
            end
          end else begin
            // Runt frames below MIN_LEN vanish without touching the outputs.
            if (cnt_q >= 5'(MIN_LEN)) begin
              data_q <= buf_q;
              mod_q  <= cnt_q[3:0];
              val_q  <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= IDLE_S;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for deserializer
module tb_deserializer;

  logic        clk;
  logic        srst;
  logic        ser_data;
  logic        ser_val;
  logic [15:0] deser_data;
  logic [3:0]  deser_mod;
  logic        deser_val;
  logic        busy;

  deserializer #(.DATA_W(16), .MIN_LEN(3)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (deser_data),
    .deser_data_mod_o (deser_mod),
    .deser_data_val_o (deser_val),
    .busy_o           (busy)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] last_d;
  logic [3:0]  last_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic d);
    ser_val  = v;
    ser_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] m);
    exp_t e;
    e.d = d; e.m = m; e.c = cyc;
    exp_q.push_back(e);
    last_d = d;
    last_m = m;
  endtask

  // Sends the top n bits of w MSB first; short frames get a gap with ser_data=1 to show it is ignored.
  task automatic frame(input logic [15:0] w, input int n, input logic [15:0] exp_d);
    for (int i = 0; i < n; i++) step(1'b1, w[15-i]);
    if (n == 16) begin
      push(exp_d, 4'd0);
    end else begin
      step(1'b0, 1'b1);
      if (n >= 3) push(exp_d, 4'(n));
    end
  endtask

  always @(negedge clk) begin
    if (deser_val) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(deser_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", 32'(deser_data), 32'(e.d));
        chk("mod", 32'(deser_mod), 32'(e.m));
        chk("pulse_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  initial begin
    srst = 1'b1; ser_val = 1'b0; ser_data = 1'b0;
    last_d = '0; last_m = '0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_data", 32'(deser_data), 32'h0);
    chk("rst_mod", 32'(deser_mod), 32'h0);
    chk("rst_val", 32'(deser_val), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    srst = 1'b0;
    step(1'b0, 1'b0);

    frame(16'b1011_0000_1111_0101, 16, 16'hB0F5);
    step(1'b0, 1'b0);
    frame(16'b1100_1000_0000_0000, 5, 16'hC800);
    step(1'b0, 1'b0);

    frame(16'b1100_0000_0000_0000, 2, 16'h0);
    chk("drop_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0);
    chk("drop_data_hold", 32'(deser_data), 32'(last_d));
    chk("drop_mod_hold", 32'(deser_mod), 32'(last_m));

    frame(16'hFFFF, 16, 16'hFFFF);
    frame(16'h0001, 16, 16'h0001);
    frame(16'b1010_0000_0000_0000, 3, 16'hA000);
    frame(16'b1111_1111_1111_1110, 15, 16'hFFFE);
    step(1'b0, 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("busy_mid_frame", 32'(busy), 32'h1);
    srst = 1'b1;
    step(1'b0, 1'b0);
    srst = 1'b0;
    chk("mid_rst_data", 32'(deser_data), 32'h0);
    chk("mid_rst_mod", 32'(deser_mod), 32'h0);
    chk("mid_rst_val", 32'(deser_val), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    frame(16'h1234, 16, 16'h1234);

    repeat (4) step(1'b0, 1'b0);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
